instr_encoder: RTL and testbench

- Inverse of the CPU's control decode path: accepts decoded instruction fields (op, funct3, funct7b5, rd, rs1, rs2, full immediate) over a valid/ready stream.
- Packs each beat into a 32-bit RV32I word, range-checks it, and writes it sequentially into instruction memory.
- Used as the program loader / self-test generator that fills imem before the core is released from reset.

---
 rtl/instr_encoder_pkg.sv | 31 +++
 rtl/instr_pack.sv | 76 +++++++
 rtl/instr_encoder.sv | 106 ++++++++++
 tb/tb_instr_encoder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcodes, formats,
// error codes, FSM encoding and an immediate range helper.
package instr_encoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OP    = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FULL} state_e;

  // True when v is the sign extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded fields -> 32-bit RV32I word plus a
// beat error code (bad opcode, immediate out of range, misaligned target).
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] wdata,
  output logic [1:0]  err_code
);

  fmt_e fmt;
  logic op_ok;
  logic is_shift;

  always_comb begin
    fmt   = FMT_R;
    op_ok = 1'b1;
    case (op)
      OP_R:                   fmt = FMT_R;
      OP_I, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:               fmt = FMT_S;
      OP_BRANCH:              fmt = FMT_B;
      OP_JAL:                 fmt = FMT_J;
      OP_LUI, OP_AUIPC:       fmt = FMT_U;
      default:                op_ok = 1'b0;
    endcase
  end

  // slli/srli/srai: funct3 001 or 101 on the I-ALU opcode
  assign is_shift = (op == OP_I) && (funct3[1:0] == 2'b01);

  // A branch/jump that is both out of range and odd reports the range error.
  always_comb begin
    wdata    = '0;
    err_code = ERR_NONE;
    case (fmt)
      FMT_R: wdata = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, op};
      FMT_I: begin
        if (is_shift) begin
          wdata = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, op};
          if (imm[31:5] != '0) err_code = ERR_RANGE;
        end else begin
          wdata = {imm[11:0], rs1, funct3, rd, op};
          if (!fits_signed(imm, 12)) err_code = ERR_RANGE;
        end
      end
      FMT_S: begin
        wdata = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        if (!fits_signed(imm, 12)) err_code = ERR_RANGE;
      end
      FMT_B: begin
        wdata = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        if (!fits_signed(imm, 13)) err_code = ERR_RANGE;
        else if (imm[0])           err_code = ERR_ALIGN;
      end
      FMT_J: begin
        wdata = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        if (!fits_signed(imm, 21)) err_code = ERR_RANGE;
        else if (imm[0])           err_code = ERR_ALIGN;
      end
      FMT_U: begin
        wdata = {imm[31:12], rd, op};
        if (imm[11:0] != '0) err_code = ERR_RANGE;
      end
      default: wdata = '0;
    endcase
    if (!op_ok) err_code = ERR_OP;
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts decoded instruction beats, encodes them and writes
// them sequentially into instruction memory starting at BASE.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [6:0]    op,
  input  logic [2:0]    funct3,
  input  logic          funct7b5,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [31:0]   imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   count,
  output state_e        dbg_state
);

  localparam logic [AW:0]   DEPTH  = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  state_e      state;
  logic [31:0] pk_wdata;
  logic [1:0]  pk_err;
  logic [1:0]  beat_err;
  logic        beat_good;
  logic        accept;
  logic [AW:0] count_inc;

  instr_pack u_pack (
    .op       (op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .wdata    (pk_wdata),
    .err_code (pk_err)
  );

  // Handshake: a beat transfers when in_valid && in_ready in a cycle without
  // start; in_ready depends only on state, and every transferred beat is
  // consumed (written or rejected) -- there is no backpressure inside a session.
  assign in_ready  = (state == ST_RUN) || (state == ST_FULL);
  assign accept    = in_valid && in_ready && !start;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign beat_err  = (state == ST_FULL) ? ERR_RANGE : pk_err;
  assign beat_good = (beat_err == ERR_NONE);
  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_A;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      count      <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (start) begin
        state     <= ST_RUN;
        count     <= '0;
        err       <= 1'b0;
        err_code  <= ERR_NONE;
        imem_addr <= BASE_A;
      end else if (accept) begin
        if (beat_good) begin
          imem_we    <= 1'b1;
          imem_addr  <= BASE_A + count[AW-1:0];
          imem_wdata <= pk_wdata;
          count      <= count_inc;
        end else begin
          err <= 1'b1;
          if (!err) err_code <= beat_err;
        end
        if (in_last) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end else if (beat_good && count_inc == DEPTH) begin
          state <= ST_FULL;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (AW=8 and AW=2) share one randomized
// beat stream and are checked against an arithmetic RV32I encoding model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int BASE = 0;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;

  logic        rdy0, we0, busy0, done0, err0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic [1:0]  code0;
  logic [8:0]  cnt0;
  state_e      dbg0;
  logic        rdy1, we1, busy1, done1, err1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;
  logic [1:0]  code1;
  logic [2:0]  cnt1;
  state_e      dbg1;

  always #5 clk = ~clk;

  instr_encoder #(.AW(8), .BASE(BASE)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .in_last(in_last), .op(op), .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
    .busy(busy0), .done(done0), .err(err0), .err_code(code0), .count(cnt0), .dbg_state(dbg0)
  );

  instr_encoder #(.AW(2), .BASE(BASE)) u_small (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .in_last(in_last), .op(op), .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .busy(busy1), .done(done1), .err(err1), .err_code(code1), .count(cnt1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0, n_errors = 0;
  logic [39:0] exp_q0[$], exp_q1[$];
  logic [31:0] log0[$];
  bit          m_active = 0, m_done = 0;
  int          depth[2] = '{256, 4};
  int          m_cnt[2] = '{0, 0};
  int          m_code[2] = '{0, 0};
  int          m_addr[2] = '{BASE, BASE};
  bit          m_err[2] = '{0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding written from the RV32I field layout with plain integer arithmetic.
  task automatic ref_encode(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [31:0] im, output logic [31:0] w, output int code);
    longint v, x, rs, rdp;
    v    = longint'($signed(im));
    rs   = (longint'(s1) << 15) | (longint'(f3) << 12) | longint'(o);
    rdp  = longint'(d) << 7;
    x    = 0;
    code = 0;
    case (o)
      7'h33: x = (longint'(f7) << 30) | (longint'(s2) << 20) | rs | rdp;
      7'h13, 7'h03, 7'h67: begin
        if (o == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          if (v < 0 || v > 31) code = 2;
          x = (longint'(f7) << 30) | ((v & 31) << 20) | rs | rdp;
        end else begin
          if (v < -2048 || v > 2047) code = 2;
          x = ((v & 'hFFF) << 20) | rs | rdp;
        end
      end
      7'h23: begin
        if (v < -2048 || v > 2047) code = 2;
        x = (((v >> 5) & 'h7F) << 25) | (longint'(s2) << 20) | rs | ((v & 'h1F) << 7);
      end
      7'h63: begin
        if (v < -4096 || v > 4095) code = 2;
        else if ((v & 1) != 0) code = 3;
        x = (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3F) << 25) | (longint'(s2) << 20) | rs
          | (((v >> 1) & 'hF) << 8) | (((v >> 11) & 1) << 7);
      end
      7'h6F: begin
        if (v < -(64'sd1 << 20) || v > (64'sd1 << 20) - 1) code = 2;
        else if ((v & 1) != 0) code = 3;
        x = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3FF) << 21) | (((v >> 11) & 1) << 20)
          | (((v >> 12) & 'hFF) << 12) | rdp | longint'(o);
      end
      7'h37, 7'h17: begin
        if ((v & 'hFFF) != 0) code = 2;
        x = (longint'(im) & 'hFFFFF000) | rdp | longint'(o);
      end
      default: code = 1;
    endcase
    w = x[31:0];
  endtask

  task automatic model_step();
    logic [31:0] w;
    int          c, e;
    if (!reset_n) begin
      m_active = 0;
      m_done   = 0;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_code[i] = 0; m_err[i] = 0; m_addr[i] = BASE;
      end
      exp_q0.delete();
      exp_q1.delete();
      return;
    end
    m_done = 0;
    if (start) begin
      m_active = 1;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_code[i] = 0; m_err[i] = 0; m_addr[i] = BASE;
      end
    end else if (in_valid && m_active) begin
      ref_encode(op, funct3, funct7b5, rd, rs1, rs2, imm, w, c);
      for (int i = 0; i < 2; i++) begin
        e = (m_cnt[i] >= depth[i]) ? 2 : c;
        if (e == 0) begin
          m_addr[i] = (BASE + m_cnt[i]) % depth[i];
          m_cnt[i]++;
          if (i == 0) exp_q0.push_back({8'(m_addr[i]), w});
          else        exp_q1.push_back({8'(m_addr[i]), w});
        end else if (!m_err[i]) begin
          m_err[i]  = 1;
          m_code[i] = e;
        end
      end
      if (in_last) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  endtask

  function automatic state_e exp_state(input int i);
    if (!m_active) return ST_IDLE;
    return (m_cnt[i] >= depth[i]) ? ST_FULL : ST_RUN;
  endfunction

  task automatic monitor_step();
    logic [39:0] e;
    chk("in_ready0", 64'(rdy0), 64'(m_active));
    chk("in_ready1", 64'(rdy1), 64'(m_active));
    chk("busy0", 64'(busy0), 64'(m_active));
    chk("busy1", 64'(busy1), 64'(m_active));
    chk("done0", 64'(done0), 64'(m_done));
    chk("done1", 64'(done1), 64'(m_done));
    chk("err0", 64'(err0), 64'(m_err[0]));
    chk("err1", 64'(err1), 64'(m_err[1]));
    chk("err_code0", 64'(code0), 64'(m_code[0]));
    chk("err_code1", 64'(code1), 64'(m_code[1]));
    chk("count0", 64'(cnt0), 64'(m_cnt[0]));
    chk("count1", 64'(cnt1), 64'(m_cnt[1]));
    chk("addr0", 64'(addr0), 64'(m_addr[0]));
    chk("addr1", 64'(addr1), 64'(m_addr[1]));
    chk("state0", 64'(dbg0), 64'(exp_state(0)));
    chk("state1", 64'(dbg1), 64'(exp_state(1)));
    if (we0) begin
      if (exp_q0.size() == 0) begin
        chk("write0_unexpected", {24'd0, addr0, wdata0}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q0.pop_front();
        chk("write0", {24'd0, addr0, wdata0}, {24'd0, e});
        log0.push_back(wdata0);
      end
    end else if (exp_q0.size() != 0) begin
      chk("write0_missing", 64'(we0), 64'd1);
      exp_q0.delete();
    end
    if (we1) begin
      if (exp_q1.size() == 0) begin
        chk("write1_unexpected", {30'd0, addr1, wdata1}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q1.pop_front();
        chk("write1", {30'd0, addr1, wdata1}, {24'd0, e});
      end
    end else if (exp_q1.size() != 0) begin
      chk("write1_missing", 64'(we1), 64'd1);
      exp_q1.delete();
    end
  endtask

  always @(posedge clk or negedge reset_n) model_step();
  always @(negedge clk) monitor_step();

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic last);
    op = o; funct3 = f3; funct7b5 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rand_beat(input logic last);
    logic [6:0]  o;
    logic [31:0] im;
    int          t;
    case ($urandom_range(0, 9))
      0: o = 7'h33; 1: o = 7'h13; 2: o = 7'h03; 3: o = 7'h67; 4: o = 7'h23;
      5: o = 7'h63; 6: o = 7'h6F; 7: o = 7'h37; 8: o = 7'h17;
      default: o = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0: begin t = int'($urandom_range(0, 8400)) - 4200; im = 32'(t); end
      1: im = 32'($urandom_range(0, 40));
      2: im = $urandom;
      3: im = $urandom & 32'hFFFFF000;
      default: begin t = int'($urandom_range(0, 1 << 21)) - (1 << 20); im = 32'(t); end
    endcase
    beat(o, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im, last);
  endtask

  task automatic check_log(input string name, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input int n);
    logic [31:0] want[4];
    want = '{w0, w1, w2, w3};
    chk({name, "_nwrites"}, 64'(log0.size()), 64'(n));
    for (int i = 0; i < n && i < log0.size(); i++) chk(name, 64'(log0[i]), 64'(want[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("reset_we", 64'(we0), 64'd0);
    chk("reset_addr", 64'(addr0), 64'(BASE));
    reset_n = 1'b1;
    tick();

    // addi / add / sub
    log0.delete();
    pulse_start();
    beat(OP_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    beat(OP_R, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    beat(OP_R, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    chk("done_with_last_write", 64'(done0 & we0), 64'd1);
    repeat (2) tick();
    check_log("alu_words", 32'h00500093, 32'h002081B3, 32'h402081B3, 32'h0, 3);
    chk("alu_count", 64'(cnt0), 64'd3);
    chk("alu_err", 64'(err0), 64'd0);

    // sw / beq / jal / lui back to back
    log0.delete();
    pulse_start();
    beat(OP_STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    beat(OP_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1'b0);
    beat(OP_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
    beat(OP_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
    repeat (2) tick();
    check_log("mix_words", 32'h0020A423, 32'hFE208CE3, 32'h008000EF, 32'h123452B7, 4);

    // error beats: bad opcode, then out-of-range addi, then misaligned beq
    log0.delete();
    pulse_start();
    beat(7'h7F, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    beat(OP_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    beat(OP_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5, 1'b0);
    chk("err_first_code", 64'(code0), 64'd1);
    chk("err_count", 64'(cnt0), 64'd0);
    beat(OP_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    chk("err_good_addr", 64'(addr0), 64'(BASE));
    tick();
    chk("err_words", 64'(log0.size()), 64'd1);

    // six good beats: the AW=2 instance fills after four
    pulse_start();
    for (int i = 0; i < 6; i++)
      beat(OP_I, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i), logic'(i == 5));
    tick();
    chk("full_count_small", 64'(cnt1), 64'd4);
    chk("full_code_small", 64'(code1), 64'd2);
    chk("full_count_big", 64'(cnt0), 64'd6);

    // start with a beat offered mid-session
    pulse_start();
    beat(OP_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    beat(7'h7F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    op = OP_I; funct3 = 3'd0; imm = 32'd9; in_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("restart_count", 64'(cnt0), 64'd0);
    chk("restart_err", 64'(err0), 64'd0);
    beat(OP_I, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1);
    chk("restart_addr", 64'(addr0), 64'(BASE));

    // reset between two accepted beats
    pulse_start();
    beat(OP_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_we", 64'(we0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    beat(OP_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4, 1'b0);
    chk("rst_idle_count", 64'(cnt0), 64'd0);

    // randomized sessions; session 5 overfills the AW=8 instance
    for (int s = 0; s < 40; s++) begin
      pulse_start();
      n = (s == 5) ? 300 : int'($urandom_range(1, 12));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
        if (s != 5 && k > 0 && $urandom_range(0, 30) == 0) begin
          in_valid = 1'b1; start = 1'b1;
          tick();
          start = 1'b0; in_valid = 1'b0;
        end
        if (s == 5) beat(OP_I, 3'($urandom_range(0, 7) & 6), 1'b0, 5'($urandom), 5'($urandom),
                         5'($urandom), 32'($urandom_range(0, 31)), logic'(k == n - 1));
        else rand_beat(logic'(k == n - 1));
      end
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    chk("q0_drained", 64'(exp_q0.size()), 64'd0);
    chk("q1_drained", 64'(exp_q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
